branch_resolve_unit: RTL and testbench
======================================

// Module: branch_resolve_unit
// PURPOSE
//  Execute-stage partner of the fetch-side branch predictor. Holds the fetch-stage predictions of in-flight branches in an in-order queue.
//  Compares each prediction with the actual outcome from execute.
//  Drives mispred/t_addr/tp_addr back to the predictor, and a redirect/flush to fetch.
// PARAMETERS
//  DEPTH  8   in-flight prediction queue entries (power of 2, >=2)
//  XLEN   32  address width
// PORTS
//  clk             in   1        clock, rising edge
//  rst             in   1        synchronous active-low reset
//  pred_valid      in   1        fetch pushes a branch prediction
//  pred_pc         in   XLEN     branch instruction address
//  pred_taken      in   1        predicted direction
//  pred_target     in   XLEN     predicted target (valid when pred_taken)
//  pred_ready      out  1        queue accepts push
//  res_valid       in   1        execute resolves oldest branch (program order)
//  res_taken       in   1        actual direction
//  res_target      in   XLEN     actual taken target
//  res_ready       out  1        queue non-empty, resolution accepted
//  mispred         out  1        1-cycle pulse to predictor
//  t_addr          out  XLEN     PC of mispredicted branch
//  tp_addr         out  XLEN     actual taken target of that branch
//  redirect_valid  out  1        1-cycle pulse: flush fetch/decode, restart
//  redirect_pc     out  XLEN     restart address
//  occupancy       out  $clog2(DEPTH)+1  live entries
// BEHAVIOUR
//  - Reset (rst=0 at posedge): queue empty, occupancy=0, mispred=0, redirect_valid=0, t_addr=tp_addr=redirect_pc=0.
//    In the cycle after reset, pred_ready=1 and res_ready=0.
//  - Circular FIFO with wr/rd pointers of $clog2(DEPTH)+1 bits; full/empty are derived from the MSB compare. Pointers wrap mod 2*DEPTH.
//  - pred_ready = !full && !redirect_valid (combinational from state). Push on pred_valid && pred_ready.
//  - res_ready = !empty. Pop on res_valid && res_ready. res_valid with an empty queue is ignored, with no state change.
//  - No same-cycle bypass: a full queue refuses a push even when a pop occurs in that cycle.
//  - A simultaneous push and pop on a non-full queue leaves occupancy unchanged.
//  - Mispredict condition on pop of head H:
//    (H.taken != res_taken) || (res_taken && H.target != res_target).
//  - Latency: all outputs are registered. mispred/redirect_valid rise in the cycle after the pop handshake and last exactly 1 cycle.
//  - On mispredict:
//    - t_addr = H.pc, tp_addr = res_target.
//    - redirect_pc = res_taken ? res_target : H.pc+4 (mod 2^XLEN, wraps).
//    - Queue is cleared at that same edge (younger entries are wrong-path), so occupancy becomes 0.
//    - A push offered in the resolving cycle is discarded.
//    - Pushes are also refused during the redirect_valid cycle, because fetch is still wrong-path.
//  - Correct prediction: entry popped. mispred, redirect_valid=0. t_addr/tp_addr/redirect_pc hold their previous values.
//  - Back-to-back resolutions are supported at 1 per cycle. A mispredict pulse is never merged with or extended by the next resolution.
//  - Reset asserted mid-operation overrides everything: the queue is dropped and pulses are cancelled at that edge.
// CONFIGURATION
//  BRU_STATS_EN defined:
//    - Adds outputs stat_branches and stat_mispreds (32 bit each, reset 0).
//    - Incremented on every pop and every mispredict respectively. They saturate at 2^32-1 and do not wrap.
//  BRU_STATS_EN undefined: those ports and counters do not exist; all other behaviour is identical.
// TESTING
//  1. Reset, then push pc=0x100 taken tgt=0x200; resolve taken 0x200 -> mispred=0, redirect=0, occupancy 1->0.
//  2. Push pc=0x100 NT; resolve taken 0x340 -> next cycle mispred=1, t_addr=0x100, tp_addr=0x340, redirect_pc=0x340, 1-cycle pulses.
//  3. Push pc=0xFFFFFFFC taken tgt=0x10; resolve not-taken -> redirect_pc=0x00000000 (wrap), mispred=1.
//  4. Push 8 entries -> pred_ready=0, 9th push ignored. Pop+push in same cycle while full -> push refused, occupancy 7.
//  5. Queue of 3, head mispredicts while pred_valid=1 -> occupancy=0 next cycle, push dropped, pred_ready=0 during the redirect cycle.
//  6. res_valid on empty queue -> no pulse. Reset mid-stream with 4 entries -> occupancy 0, no mispred. With BRU_STATS_EN, check the counters after tests 1-2 read 2 and 1.

Source files
------------

// File: rtl/branch_resolve_unit.sv
// In-order queue of fetch-side branch predictions, checked against execute outcomes.
// Optional BRU_STATS_EN adds saturating branch/mispredict counters.
module branch_resolve_unit #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned XLEN  = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     pred_valid,
  input  logic [XLEN-1:0]          pred_pc,
  input  logic                     pred_taken,
  input  logic [XLEN-1:0]          pred_target,
  output logic                     pred_ready,
  input  logic                     res_valid,
  input  logic                     res_taken,
  input  logic [XLEN-1:0]          res_target,
  output logic                     res_ready,
  output logic                     mispred,
  output logic [XLEN-1:0]          t_addr,
  output logic [XLEN-1:0]          tp_addr,
  output logic                     redirect_valid,
  output logic [XLEN-1:0]          redirect_pc,
  output logic [$clog2(DEPTH):0]   occupancy
`ifdef BRU_STATS_EN
  ,
  output logic [31:0]              stat_branches,
  output logic [31:0]              stat_mispreds
`endif
);

  localparam int unsigned IdxW = $clog2(DEPTH);
  localparam int unsigned PtrW = IdxW + 1;

  logic [XLEN-1:0] pc_mem  [DEPTH];
  logic [XLEN-1:0] tgt_mem [DEPTH];
  logic [DEPTH-1:0] taken_mem;

  logic [PtrW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic            mispred_q, mispred_d;
  logic            redirect_q, redirect_d;
  logic [XLEN-1:0] t_addr_q, t_addr_d, tp_addr_q, tp_addr_d, redir_pc_q, redir_pc_d;

  logic full, empty, push, pop, mis;
  logic [IdxW-1:0] wr_idx, rd_idx;
  logic [XLEN-1:0] h_pc, h_tgt;
  logic            h_taken;

  assign wr_idx = wr_q[IdxW-1:0];
  assign rd_idx = rd_q[IdxW-1:0];
  assign empty  = (wr_q == rd_q);
  assign full   = (wr_q[IdxW] != rd_q[IdxW]) && (wr_idx == rd_idx);

  // Fetch is still on the wrong path while the redirect pulse is out.
  assign pred_ready = !full && !redirect_q;
  assign res_ready  = !empty;
  assign push       = pred_valid && pred_ready;
  assign pop        = res_valid && res_ready;

  assign h_pc    = pc_mem[rd_idx];
  assign h_tgt   = tgt_mem[rd_idx];
  assign h_taken = taken_mem[rd_idx];
  assign mis     = pop && ((h_taken != res_taken) || (res_taken && (h_tgt != res_target)));

  always_comb begin
    wr_d       = wr_q + PtrW'(push);
    rd_d       = rd_q + PtrW'(pop);
    mispred_d  = mis;
    redirect_d = mis;
    t_addr_d   = t_addr_q;
    tp_addr_d  = tp_addr_q;
    redir_pc_d = redir_pc_q;
    if (mis) begin
      // Everything younger than the mispredicted branch is wrong-path.
      wr_d       = '0;
      rd_d       = '0;
      t_addr_d   = h_pc;
      tp_addr_d  = res_target;
      redir_pc_d = res_taken ? res_target : h_pc + XLEN'(4);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_idx]    <= pred_pc;
      tgt_mem[wr_idx]   <= pred_target;
      taken_mem[wr_idx] <= pred_taken;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_q       <= '0;
      rd_q       <= '0;
      mispred_q  <= 1'b0;
      redirect_q <= 1'b0;
      t_addr_q   <= '0;
      tp_addr_q  <= '0;
      redir_pc_q <= '0;
    end else begin
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      mispred_q  <= mispred_d;
      redirect_q <= redirect_d;
      t_addr_q   <= t_addr_d;
      tp_addr_q  <= tp_addr_d;
      redir_pc_q <= redir_pc_d;
    end
  end

  assign mispred        = mispred_q;
  assign redirect_valid = redirect_q;
  assign t_addr         = t_addr_q;
  assign tp_addr        = tp_addr_q;
  assign redirect_pc    = redir_pc_q;
  assign occupancy      = wr_q - rd_q;

`ifdef BRU_STATS_EN
  logic [31:0] br_cnt_q, mis_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      br_cnt_q  <= '0;
      mis_cnt_q <= '0;
    end else begin
      if (pop && (br_cnt_q != '1))  br_cnt_q  <= br_cnt_q + 32'd1;
      if (mis && (mis_cnt_q != '1)) mis_cnt_q <= mis_cnt_q + 32'd1;
    end
  end

  assign stat_branches = br_cnt_q;
  assign stat_mispreds = mis_cnt_q;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed self-checking bench for branch_resolve_unit (DEPTH=8, XLEN=32).
module tb_branch_resolve_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        pred_valid, pred_taken, res_valid, res_taken;
  logic [31:0] pred_pc, pred_target, res_target;
  logic        pred_ready, res_ready, mispred, redirect_valid;
  logic [31:0] t_addr, tp_addr, redirect_pc;
  logic [3:0]  occupancy;
`ifdef BRU_STATS_EN
  logic [31:0] stat_branches, stat_mispreds;
`endif

  int total = 0;
  int fails = 0;

  branch_resolve_unit #(.DEPTH(8), .XLEN(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .pred_valid     (pred_valid),
    .pred_pc        (pred_pc),
    .pred_taken     (pred_taken),
    .pred_target    (pred_target),
    .pred_ready     (pred_ready),
    .res_valid      (res_valid),
    .res_taken      (res_taken),
    .res_target     (res_target),
    .res_ready      (res_ready),
    .mispred        (mispred),
    .t_addr         (t_addr),
    .tp_addr        (tp_addr),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .occupancy      (occupancy)
`ifdef BRU_STATS_EN
    ,
    .stat_branches  (stat_branches),
    .stat_mispreds  (stat_mispreds)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    pred_valid = 1'b0;
    res_valid  = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    pred_valid = 0; pred_pc = 0; pred_taken = 0; pred_target = 0;
    res_valid = 0; res_taken = 0; res_target = 0;
    tick(); tick();
    rst = 1'b1;

    // Reset state
    chk("rst_occ", 32'(occupancy), 0);
    chk("rst_mispred", 32'(mispred), 0);
    chk("rst_redir", 32'(redirect_valid), 0);
    chk("rst_taddr", t_addr, 0);
    chk("rst_tpaddr", tp_addr, 0);
    chk("rst_redir_pc", redirect_pc, 0);
    chk("rst_pred_ready", 32'(pred_ready), 1);
    chk("rst_res_ready", 32'(res_ready), 0);

    // 1: correct taken prediction
    pred_valid = 1; pred_pc = 32'h100; pred_taken = 1; pred_target = 32'h200;
    tick(); idle();
    chk("t1_occ1", 32'(occupancy), 1);
    chk("t1_res_ready", 32'(res_ready), 1);
    res_valid = 1; res_taken = 1; res_target = 32'h200;
    tick(); idle();
    chk("t1_mispred", 32'(mispred), 0);
    chk("t1_redir", 32'(redirect_valid), 0);
    chk("t1_occ0", 32'(occupancy), 0);

    // 2: predicted not-taken, actually taken
    pred_valid = 1; pred_pc = 32'h100; pred_taken = 0; pred_target = 32'h0;
    tick(); idle();
    res_valid = 1; res_taken = 1; res_target = 32'h340;
    tick(); idle();
    chk("t2_mispred", 32'(mispred), 1);
    chk("t2_redir", 32'(redirect_valid), 1);
    chk("t2_taddr", t_addr, 32'h100);
    chk("t2_tpaddr", tp_addr, 32'h340);
    chk("t2_redir_pc", redirect_pc, 32'h340);
    chk("t2_pred_ready", 32'(pred_ready), 0);
    tick();
    chk("t2_mispred_end", 32'(mispred), 0);
    chk("t2_redir_end", 32'(redirect_valid), 0);
    chk("t2_taddr_hold", t_addr, 32'h100);
`ifdef BRU_STATS_EN
    chk("stat_branches", stat_branches, 2);
    chk("stat_mispreds", stat_mispreds, 1);
`endif

    // 3: not-taken fall-through wraps past 2^32
    pred_valid = 1; pred_pc = 32'hFFFF_FFFC; pred_taken = 1; pred_target = 32'h10;
    tick(); idle();
    res_valid = 1; res_taken = 0; res_target = 32'h0;
    tick(); idle();
    chk("t3_mispred", 32'(mispred), 1);
    chk("t3_taddr", t_addr, 32'hFFFF_FFFC);
    chk("t3_redir_pc", redirect_pc, 32'h0);
    tick();

    // 4: fill to full, overflow push and pop+push while full
    for (int i = 0; i < 8; i++) begin
      pred_valid = 1; pred_pc = 32'h1000 + 32'(i) * 4; pred_taken = 0; pred_target = 0;
      tick();
    end
    idle();
    chk("t4_occ8", 32'(occupancy), 8);
    chk("t4_full_ready", 32'(pred_ready), 0);
    pred_valid = 1; pred_pc = 32'h2000;
    tick(); idle();
    chk("t4_ninth", 32'(occupancy), 8);
    pred_valid = 1; pred_pc = 32'h3000; res_valid = 1; res_taken = 0;
    tick(); idle();
    chk("t4_popfull_occ", 32'(occupancy), 7);
    chk("t4_popfull_mis", 32'(mispred), 0);

    // 5: drain to 3, then head mispredicts with a push offered
    for (int i = 0; i < 4; i++) begin
      res_valid = 1; res_taken = 0;
      tick();
    end
    idle();
    chk("t5_occ3", 32'(occupancy), 3);
    res_valid = 1; res_taken = 1; res_target = 32'h500;
    pred_valid = 1; pred_pc = 32'h4000; pred_taken = 0;
    tick();
    res_valid = 0;
    chk("t5_occ0", 32'(occupancy), 0);
    chk("t5_mispred", 32'(mispred), 1);
    chk("t5_taddr", t_addr, 32'h1014);
    chk("t5_redir_pc", redirect_pc, 32'h500);
    chk("t5_pred_ready", 32'(pred_ready), 0);
    tick(); idle();
    chk("t5_redir_push", 32'(occupancy), 0);
    chk("t5_ready_back", 32'(pred_ready), 1);

    // 6: resolve on empty, then reset mid-stream
    res_valid = 1; res_taken = 1; res_target = 32'h777;
    tick(); idle();
    chk("t6_empty_mis", 32'(mispred), 0);
    chk("t6_empty_occ", 32'(occupancy), 0);
    for (int i = 0; i < 4; i++) begin
      pred_valid = 1; pred_pc = 32'h6000 + 32'(i) * 4; pred_taken = 0;
      tick();
    end
    idle();
    chk("t6_occ4", 32'(occupancy), 4);
    rst = 0; res_valid = 1; res_taken = 1; res_target = 32'h900;
    tick(); idle();
    rst = 1;
    chk("t6_rst_occ", 32'(occupancy), 0);
    chk("t6_rst_mis", 32'(mispred), 0);
    chk("t6_rst_redir", 32'(redirect_valid), 0);
    chk("t6_rst_taddr", t_addr, 0);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
